// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared helpers, parameter-legality functions and the registered flag bundle
// used by the sync_fifo block.
package sync_fifo_pkg;

    localparam int PTR_WRAP_BITS   = 1;
    localparam int MIN_DEPTH_WIDTH = 2;
    localparam int MAX_DEPTH_WIDTH = 20;
    localparam int MAX_DATA_WIDTH  = 1152;

    typedef struct packed {
        logic wr_full;
        logic almost_full;
        logic rd_empty;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        wr_full:      1'b0,
        almost_full:  1'b0,
        rd_empty:     1'b1,
        almost_empty: 1'b1
    };

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // One extra pointer bit separates the full and empty cases when the address bits match.
    function automatic int ptr_width(input int depth_width);
        return depth_width + PTR_WRAP_BITS;
    endfunction

    function automatic bit threshold_ok(input int num, input int depth_width);
        return (num >= 1) && (num <= (1 << depth_width) - 1);
    endfunction

    function automatic bit geometry_ok(input int data_width, input int depth_width);
        return (data_width >= 1) && (data_width <= MAX_DATA_WIDTH) &&
               (depth_width >= MIN_DEPTH_WIDTH) && (depth_width <= MAX_DEPTH_WIDTH);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: write, read, status and error signals of sync_fifo; master is the user side,
// slave is the FIFO.
interface sync_fifo_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 8
);

    logic                                            wr_en;
    logic [DATA_WIDTH-1:0]                           wr_data;
    logic                                            wr_full;
    logic                                            almost_full;
    logic                                            rd_en;
    logic [DATA_WIDTH-1:0]                           rd_data;
    logic                                            rd_valid;
    logic                                            rd_empty;
    logic                                            almost_empty;
    logic [sync_fifo_pkg::ptr_width(DEPTH_WIDTH)-1:0] water_level;
    logic                                            err_clr;
    logic                                            wr_overflow;
    logic                                            rd_underflow;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  wr_full, almost_full, rd_data, rd_valid, rd_empty, almost_empty,
               water_level, wr_overflow, rd_underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output wr_full, almost_full, rd_data, rd_valid, rd_empty, almost_empty,
               water_level, wr_overflow, rd_underflow
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port RAM with one write port and one registered read port,
// DATA_WIDTH x 2^ADDR_WIDTH.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered flags, thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have 1-cycle latency.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH_WIDTH      = 8,
    parameter int ALMOST_FULL_NUM  = 252,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input logic        clk,
    input logic        rst_n,
    sync_fifo_if.slave bus
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam int AW    = clog2(DEPTH);
    localparam int PW    = ptr_width(DEPTH_WIDTH);

    localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT    = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0] AE_CNT    = PW'(ALMOST_EMPTY_NUM);

    if (!geometry_ok(DATA_WIDTH, DEPTH_WIDTH)) begin : g_bad_geometry
        $error("sync_fifo: DATA_WIDTH=%0d or DEPTH_WIDTH=%0d out of range", DATA_WIDTH, DEPTH_WIDTH);
    end
    if (!threshold_ok(ALMOST_FULL_NUM, DEPTH_WIDTH)) begin : g_bad_almost_full
        $error("sync_fifo: ALMOST_FULL_NUM=%0d outside 1..depth-1", ALMOST_FULL_NUM);
    end
    if (!threshold_ok(ALMOST_EMPTY_NUM, DEPTH_WIDTH)) begin : g_bad_almost_empty
        $error("sync_fifo: ALMOST_EMPTY_NUM=%0d outside 1..depth-1", ALMOST_EMPTY_NUM);
    end

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         count_q, count_d;
    fifo_flags_t           flags_q, flags_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_acc, rd_acc, empty_d;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign wr_acc = bus.wr_en && !flags_q.wr_full;
    assign rd_acc = bus.rd_en && !flags_q.rd_empty;
    assign wptr_d = wptr_q + PW'(wr_acc);

    // NOTE: each always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        flags_d              = FLAGS_RESET;
        flags_d.wr_full      = (count_d == DEPTH_CNT);
        flags_d.almost_full  = (count_d >= AF_CNT);
        flags_d.rd_empty     = empty_d;
        flags_d.almost_empty = (count_d <= AE_CNT);

        ovf_d = ovf_q && !bus.err_clr;
        unf_d = unf_q && !bus.err_clr;
        if (bus.wr_en && flags_q.wr_full) begin
            ovf_d = 1'b1;
        end
        if (bus.rd_en && flags_q.rd_empty) begin
            unf_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            flags_q <= FLAGS_RESET;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(AW)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (wr_acc),
        .waddr_i(wptr_q[AW-1:0]),
        .wdata_i(bus.wr_data),
        .re_i   (ram_re),
        .raddr_i(rptr_q[AW-1:0]),
        .rdata_o(ram_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Two-stage prefetch: RAM read register then output register; rd_en acknowledges the head word.
    logic                  ram_v_q, ram_v_d;
    logic                  out_v_q, out_v_d;
    logic                  out_load;
    logic [DATA_WIDTH-1:0] out_data_q;

    assign out_load = ram_v_q && (!out_v_q || rd_acc);
    assign ram_re   = (wptr_q != rptr_q) && (!ram_v_q || out_load);
    assign ram_v_d  = ram_re || (ram_v_q && !out_load);
    assign out_v_d  = out_load || (out_v_q && !rd_acc);
    assign rptr_d   = rptr_q + PW'(ram_re);
    assign count_d  = (wptr_d - rptr_d) + PW'(ram_v_d) + PW'(out_v_d);
    assign empty_d  = !out_v_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_v_q    <= 1'b0;
            out_v_q    <= 1'b0;
            out_data_q <= '0;
        end else begin
            ram_v_q <= ram_v_d;
            out_v_q <= out_v_d;
            if (out_load) begin
                out_data_q <= ram_rdata;
            end
        end
    end

    assign bus.rd_data  = out_data_q;
    assign bus.rd_valid = !flags_q.rd_empty;
`else
    logic rd_valid_q;

    assign ram_re  = rd_acc;
    assign rptr_d  = rptr_q + PW'(rd_acc);
    assign count_d = wptr_d - rptr_d;
    assign empty_d = (count_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
        end
    end

    assign bus.rd_data  = ram_rdata;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.wr_full      = flags_q.wr_full;
    assign bus.almost_full  = flags_q.almost_full;
    assign bus.rd_empty     = flags_q.rd_empty;
    assign bus.almost_empty = flags_q.almost_empty;
    assign bus.water_level  = count_q;
    assign bus.wr_overflow  = ovf_q;
    assign bus.rd_underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo; a queue model of the FIFO is compared every cycle,
// with literal expectations at the interesting points.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DPW   = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DPW)) bus ();

    sync_fifo #(
        .DATA_WIDTH      (DW),
        .DEPTH_WIDTH     (DPW),
        .ALMOST_FULL_NUM (AF),
        .ALMOST_EMPTY_NUM(AE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    int            rv_count;
    bit            chk_en   = 1'b0;

    logic [DW-1:0] mq[$];
    logic          m_ovf;
    logic          m_unf;
    logic          m_rd_valid;
    logic [DW-1:0] m_rd_data;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
        m_rd_valid = 1'b0;
        m_rd_data  = '0;
    endfunction

    // Applies the FIFO rules to the inputs present at the clock edge.
    task automatic model_step();
        bit wr_ok;
        bit rd_ok;
        if (!rst_n) begin
            model_reset();
            return;
        end
        wr_ok = bus.wr_en && (mq.size() < DEPTH);
        rd_ok = bus.rd_en && (mq.size() > 0);
        if (bus.err_clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (bus.wr_en && !wr_ok) m_ovf = 1'b1;
        if (bus.rd_en && !rd_ok) m_unf = 1'b1;
        m_rd_valid = rd_ok;
        if (rd_ok) m_rd_data = mq.pop_front();
        if (wr_ok) mq.push_back(bus.wr_data);
    endtask

    task automatic cycle(input logic wr, input logic [DW-1:0] data, input logic rd, input logic clr);
        bus.wr_en   = wr;
        bus.wr_data = data;
        bus.rd_en   = rd;
        bus.err_clr = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("water_level",  bus.water_level,  mq.size());
            check("wr_full",      bus.wr_full,      mq.size() == DEPTH);
            check("almost_full",  bus.almost_full,  mq.size() >= AF);
            check("almost_empty", bus.almost_empty, mq.size() <= AE);
            check("wr_overflow",  bus.wr_overflow,  m_ovf);
            check("rd_underflow", bus.rd_underflow, m_unf);
`ifndef SYNC_FIFO_FWFT_EN
            check("rd_empty",     bus.rd_empty,     mq.size() == 0);
            check("rd_valid",     bus.rd_valid,     m_rd_valid);
            check("rd_data",      bus.rd_data,      m_rd_data);
`endif
        end
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        check("rst_rd_empty",     bus.rd_empty,     1);
        check("rst_almost_empty", bus.almost_empty, 1);
        check("rst_wr_full",      bus.wr_full,      0);
        check("rst_almost_full",  bus.almost_full,  0);
        check("rst_water_level",  bus.water_level,  0);
        check("rst_rd_data",      bus.rd_data,      0);
        check("rst_rd_valid",     bus.rd_valid,     0);
        check("rst_wr_overflow",  bus.wr_overflow,  0);
        check("rst_rd_underflow", bus.rd_underflow, 0);

        rst_n  = 1'b1;
        chk_en = 1'b1;
        cycle(0, 8'h00, 0, 0);
        check("post_rst_rd_empty", bus.rd_empty,    1);
        check("post_rst_level",    bus.water_level, 0);

`ifndef SYNC_FIFO_FWFT_EN
        for (int i = 0; i < 16; i++) begin
            cycle(1, 8'(i), 0, 0);
            if (i == 1)  check("fill_ae_high_after_2",   bus.almost_empty, 1);
            if (i == 2)  check("fill_ae_low_after_3",    bus.almost_empty, 0);
            if (i == 12) check("fill_af_low_after_13",   bus.almost_full,  0);
            if (i == 13) check("fill_af_high_after_14",  bus.almost_full,  1);
            if (i == 14) check("fill_full_low_after_15", bus.wr_full,      0);
        end
        check("fill_full",  bus.wr_full,     1);
        check("fill_level", bus.water_level, 16);

        cycle(1, 8'hAA, 0, 0);
        check("ovf_set",   bus.wr_overflow, 1);
        check("ovf_level", bus.water_level, 16);
        cycle(0, 8'h00, 0, 1);
        check("ovf_clr", bus.wr_overflow, 0);

        cycle(1, 8'hBB, 1, 0);
        check("full_rw_level", bus.water_level, 15);
        check("full_rw_ovf",   bus.wr_overflow, 1);
        check("full_rw_valid", bus.rd_valid,    1);
        check("full_rw_data",  bus.rd_data,     8'h00);
        cycle(0, 8'h00, 0, 1);
        check("rd_valid_pulse", bus.rd_valid, 0);
        check("rd_data_hold",   bus.rd_data,  8'h00);

        for (int i = 1; i < 16; i++) begin
            cycle(0, 8'h00, 1, 0);
            check("drain_data", bus.rd_data, i);
        end
        check("drain_empty", bus.rd_empty,    1);
        check("drain_level", bus.water_level, 0);

        rv_count = 0;
        for (int i = 0; i < 41; i++) begin
            cycle(i < 40, 8'(8'h40 + i), i > 0, 0);
            if (bus.rd_valid) begin
                check("wrap_data", bus.rd_data, 8'h40 + i - 1);
                rv_count++;
            end
        end
        check("wrap_rd_valid_count", rv_count,         40);
        check("wrap_no_underflow",   bus.rd_underflow, 0);

        cycle(0, 8'h00, 1, 0);
        check("empty_rd_unf",   bus.rd_underflow, 1);
        check("empty_rd_valid", bus.rd_valid,     0);
        cycle(0, 8'h00, 0, 1);

        cycle(1, 8'h77, 1, 0);
        check("empty_rw_level", bus.water_level,  1);
        check("empty_rw_unf",   bus.rd_underflow, 1);
        cycle(0, 8'h00, 1, 0);
        check("empty_rw_data",   bus.rd_data,      8'h77);
        check("unf_sticky",      bus.rd_underflow, 1);
        cycle(0, 8'h00, 1, 1);
        check("err_beats_clear", bus.rd_underflow, 1);
        cycle(0, 8'h00, 0, 1);
        check("unf_clr",         bus.rd_underflow, 0);

        cycle(1, 8'h11, 0, 0);
        cycle(1, 8'h22, 0, 0);
        cycle(1, 8'h33, 0, 0);
        cycle(0, 8'h00, 1, 0);
        check("pre_reset_data", bus.rd_data, 8'h11);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_data",  bus.rd_data,     0);
        check("async_rst_level", bus.water_level, 0);
        check("async_rst_empty", bus.rd_empty,    1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 8'h99, 0, 0);
        cycle(0, 8'h00, 1, 0);
        check("post_reset_data", bus.rd_data, 8'h99);
`else
        cycle(1, 8'h5A, 0, 0);
        check("fwft_valid_n0", bus.rd_valid, 0);
        cycle(0, 8'h00, 0, 0);
        check("fwft_valid_n1", bus.rd_valid, 0);
        cycle(0, 8'h00, 0, 0);
        check("fwft_valid_n2", bus.rd_valid,    1);
        check("fwft_data_n2",  bus.rd_data,     8'h5A);
        check("fwft_level_n2", bus.water_level, 1);
        cycle(0, 8'h00, 1, 0);
        check("fwft_ack_valid", bus.rd_valid,    0);
        check("fwft_ack_level", bus.water_level, 0);

        chk_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(i < 4, 8'(i + 1), 1, 0);
            check("fwft_b2b_valid", bus.rd_valid, (i >= 2) && (i <= 5));
            if ((i >= 2) && (i <= 5)) check("fwft_b2b_data", bus.rd_data, i - 1);
        end
        check("fwft_b2b_unf", bus.rd_underflow, 1);
        cycle(0, 8'h00, 0, 1);
        chk_en = 1'b1;
        cycle(0, 8'h00, 0, 0);
        check("fwft_b2b_level", bus.water_level, 0);
`endif

        cycle(0, 8'h00, 0, 0);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO for the Logos-family designs. It is the single-domain successor of the vendor async FIFO wrapper, for datapaths where producer and consumer share one clock. It adds registered occupancy flags, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, a read-valid strobe, and an optional first-word-fall-through (FWFT) read mode. Typical placement is between a streaming source (UART, ADC, Ethernet MAC) and a consumer clocked by the same PLL output.

## Interface
Parameters:
- DATA_WIDTH, 8: word width, 1..1152
- DEPTH_WIDTH, 8: log2 of depth; depth = 2^DEPTH_WIDTH, 2..20
- ALMOST_FULL_NUM, 252: almost_full asserts when count ≥ this value; legal range 1..depth-1
- ALMOST_EMPTY_NUM, 4: almost_empty asserts when count ≤ this value; legal range 1..depth-1

Ports:
- clk, in, 1: single clock, rising edge
- rst_n, in, 1: asynchronous active-low reset
- wr_en, in, 1: write request
- wr_data, in, DATA_WIDTH: write data
- wr_full, out, 1: FIFO full
- almost_full, out, 1: count ≥ ALMOST_FULL_NUM
- rd_en, in, 1: read request (standard mode) or acknowledge (FWFT mode)
- rd_data, out, DATA_WIDTH: read data
- rd_valid, out, 1: rd_data holds a newly read word
- rd_empty, out, 1: FIFO empty
- almost_empty, out, 1: count ≤ ALMOST_EMPTY_NUM
- water_level, out, DEPTH_WIDTH+1: current occupancy, 0..depth
- err_clr, in, 1: synchronous clear of both error flags
- wr_overflow, out, 1: sticky; a write was attempted while full
- rd_underflow, out, 1: sticky; a read was attempted while empty

## Operation
- Accepted write: wr_en && !wr_full. Accepted read: rd_en && !rd_empty. Both are evaluated on flag values at the start of the cycle.
- Pointers are DEPTH_WIDTH+1 bits and wrap modulo 2·depth. The MSB distinguishes full from empty.
- Count = wptr − rptr, computed mod 2^(DEPTH_WIDTH+1). water_level is that count, registered.
- Flag definitions:
  - wr_full = (count == depth)
  - rd_empty = (count == 0)
  - almost_full = (count ≥ ALMOST_FULL_NUM)
  - almost_empty = (count ≤ ALMOST_EMPTY_NUM)
  - All flags are registered and updated on the same edge as the pointer update.
- Simultaneous read and write:
  - When full: the read is accepted and the write is rejected. Count goes to depth−1 and wr_overflow sets.
  - When empty: the write is accepted and the read is rejected. Count goes to 1 and rd_underflow sets.
  - Otherwise both are accepted and count is unchanged.
- Rejected operations leave memory and pointers untouched.
- Error flags set on a rejected request. They clear only on err_clr or reset. If err_clr and a new error occur in the same cycle, the error wins.
- Reset values: rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, water_level=0, rd_data=0, rd_valid=0, wr_overflow=0, rd_underflow=0.
- Reset mid-operation: pointers clear immediately and contents are discarded. rd_data returns to 0 asynchronously.

## Timing
- Standard mode:
  - rd_data and rd_valid appear 1 cycle after the accepted read.
  - rd_valid is a single-cycle pulse per accepted read.
  - rd_data holds its value between reads.
  - Write at edge N: rd_empty deasserts after edge N, so a read is possible in cycle N+1.
- FWFT mode:
  - The head word is presented on rd_data and rd_valid = !rd_empty.
  - The first word written into an empty FIFO becomes visible 2 cycles after the write edge (RAM read followed by output register).
  - rd_en acts as an acknowledge. The next word is presented in the following cycle with no bubble while the FIFO is non-empty.
  - Count and water_level include the word held in the output register.
- Sustained throughput is one write and one read per cycle in both modes.

## Configuration
- Macro SYNC_FIFO_FWFT_EN:
  - Defined: FWFT read mode as described above, with prefetch logic and an output-register-aware occupancy count.
  - Undefined: standard mode with 1-cycle read latency and no prefetch logic.
- Both builds use identical ports.

## Structure
- Package sync_fifo_pkg holds:
  - function clog2
  - pointer-width helper localparams
  - parameter-legality checks: elaboration-time $error when a threshold is outside 1..depth-1
- Sub-module sync_fifo_ram: simple dual-port RAM with one write port and one registered read port, DATA_WIDTH × depth, inferable as DRM.
- The top level holds the pointers, flags, error logic and FWFT prefetch logic.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH_WIDTH=4, ALMOST_FULL_NUM=14, ALMOST_EMPTY_NUM=2.
- Reset: hold rst_n=0 → all outputs at their reset values. After release, rd_empty=1 and water_level=0.
- Fill: write 0x00..0x0F → almost_full after the 14th write, wr_full after the 16th, water_level=16, almost_empty low after the 3rd write.
- Overflow: write 0xAA while full → contents unchanged, wr_overflow=1. Pulse err_clr → wr_overflow=0.
- Drain with pointer wrap: interleave 40 writes and reads → data order preserved, rd_valid count=40, rd_underflow stays 0. Reading while empty sets rd_underflow.
- Simultaneous read+write at full (16) → water_level=15, wr_overflow=1. Repeat at empty (0) → water_level=1, rd_underflow=1.
- FWFT build: write 0x5A into an empty FIFO → rd_valid=1 with rd_data=0x5A two cycles later. Back-to-back writes 0x01..0x04 with rd_en held high → one word per cycle, no bubble.
